// File: rtl/pwr_est_pkg.sv
// Shared types and constants for the ALU switching-activity power estimator.
// Optional per-class toggle breakdown is enabled with TOGGLE_BREAKDOWN_EN.
package pwr_est_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Flag vector layout {S,Cr,Ze,P,O}
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned FLG_O  = 0;
    localparam int unsigned FLG_P  = 1;
    localparam int unsigned FLG_ZE = 2;
    localparam int unsigned FLG_CR = 3;
    localparam int unsigned FLG_S  = 4;

    localparam int unsigned DEF_W_IN   = 1;
    localparam int unsigned DEF_W_OUT  = 2;
    localparam int unsigned DEF_W_FLAG = 1;
    localparam int unsigned W_MAX      = 15;

endpackage

// File: rtl/toggle_popcount.sv
// Combinational Hamming distance between two N-bit words.
module toggle_popcount #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]              a,
    input  logic [N-1:0]              b,
    output logic [$clog2(N+1)-1:0]    cnt_c
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0] diff;

    assign diff = a ^ b;

    always_comb begin
        cnt_c = '0;
        for (int i = 0; i < N; i++) begin
            cnt_c = cnt_c + CW'(diff[i]);
        end
    end

endmodule

// File: rtl/alu_toggle_monitor.sv
// Per-window weighted toggle-energy estimator sitting on the ALU sample stream.
// Define TOGGLE_BREAKDOWN_EN to add unweighted per-class toggle sums.
module alu_toggle_monitor
    import pwr_est_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned WIN_LOG2 = 4,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned W_IN     = DEF_W_IN,
    parameter int unsigned W_OUT    = DEF_W_OUT,
    parameter int unsigned W_FLAG   = DEF_W_FLAG
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  smp_valid,
    output logic                  smp_ready,
    input  logic [WIDTH-1:0]      smp_x,
    input  logic [WIDTH-1:0]      smp_y,
    input  logic [WIDTH-1:0]      smp_z,
    input  logic [FLAG_W-1:0]     smp_flags,
    output logic                  est_valid,
    input  logic                  est_ready,
    output logic [ACC_W-1:0]      est_energy,
    output logic [WIN_LOG2:0]     est_samples,
    output logic                  busy,
    output logic                  overflow
`ifdef TOGGLE_BREAKDOWN_EN
    ,
    output logic [ACC_W-1:0]      est_in_tog,
    output logic [ACC_W-1:0]      est_out_tog,
    output logic [ACC_W-1:0]      est_flag_tog
`endif
);

    localparam int unsigned XW    = $clog2(WIDTH + 1);
    localparam int unsigned FW    = $clog2(FLAG_W + 1);
    localparam int unsigned T_MAX = (4 * WIDTH + FLAG_W) * W_MAX;
    localparam int unsigned T_W   = $clog2(T_MAX + 1);
    localparam int unsigned SUM_W = ((ACC_W > T_W) ? ACC_W : T_W) + 1;
    localparam int unsigned WIN_N = 1 << WIN_LOG2;
    localparam int unsigned SMP_W = WIN_LOG2 + 1;

    // Saturating add; MSB of the result flags that saturation occurred
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [T_W-1:0]   b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({ACC_W{1'b1}})) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = {1'b0, s[ACC_W-1:0]};
        end
    endfunction

    state_t              state;
    logic [WIDTH-1:0]    prev_x;
    logic [WIDTH-1:0]    prev_y;
    logic [WIDTH-1:0]    prev_z;
    logic [FLAG_W-1:0]   prev_f;
    logic [ACC_W-1:0]    acc;
    logic [WIN_LOG2-1:0] count;
    logic                primed;

    logic [XW-1:0]       cnt_x;
    logic [XW-1:0]       cnt_y;
    logic [XW-1:0]       cnt_z;
    logic [FW-1:0]       cnt_f;
    logic [T_W-1:0]      tog_c;
    logic [ACC_W:0]      acc_sum_c;
    logic                accept_c;
    logic                last_c;

    toggle_popcount #(.N(WIDTH))  u_pc_x (.a(smp_x),     .b(prev_x), .cnt_c(cnt_x));
    toggle_popcount #(.N(WIDTH))  u_pc_y (.a(smp_y),     .b(prev_y), .cnt_c(cnt_y));
    toggle_popcount #(.N(WIDTH))  u_pc_z (.a(smp_z),     .b(prev_z), .cnt_c(cnt_z));
    toggle_popcount #(.N(FLAG_W)) u_pc_f (.a(smp_flags), .b(prev_f), .cnt_c(cnt_f));

    assign accept_c = smp_valid & smp_ready;
    assign last_c   = (count == WIN_LOG2'(WIN_N - 1));

    // The first sample after start only seeds the previous-value registers
    always_comb begin
        tog_c = '0;
        if (primed) begin
            tog_c = T_W'(W_IN) * (T_W'(cnt_x) + T_W'(cnt_y))
                  + T_W'(W_OUT) * T_W'(cnt_z)
                  + T_W'(W_FLAG) * T_W'(cnt_f);
        end
        acc_sum_c = sat_add(acc, tog_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            smp_ready   <= 1'b0;
            busy        <= 1'b0;
            est_valid   <= 1'b0;
            est_energy  <= '0;
            est_samples <= '0;
            overflow    <= 1'b0;
            prev_x      <= '0;
            prev_y      <= '0;
            prev_z      <= '0;
            prev_f      <= '0;
            acc         <= '0;
            count       <= '0;
            primed      <= 1'b0;
        end else if (start) begin
            // Restart from any state; a pending estimate is dropped
            state     <= ACCUM;
            smp_ready <= 1'b1;
            busy      <= 1'b1;
            est_valid <= 1'b0;
            overflow  <= 1'b0;
            acc       <= '0;
            count     <= '0;
            primed    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        prev_x   <= smp_x;
                        prev_y   <= smp_y;
                        prev_z   <= smp_z;
                        prev_f   <= smp_flags;
                        primed   <= 1'b1;
                        acc      <= acc_sum_c[ACC_W-1:0];
                        overflow <= overflow | acc_sum_c[ACC_W];
                        count    <= count + WIN_LOG2'(1);
                        if (last_c) begin
                            state       <= REPORT;
                            smp_ready   <= 1'b0;
                            est_valid   <= 1'b1;
                            est_energy  <= acc_sum_c[ACC_W-1:0];
                            est_samples <= SMP_W'(WIN_N);
                        end
                    end
                end
                REPORT: begin
                    if (est_ready) begin
                        state     <= ACCUM;
                        smp_ready <= 1'b1;
                        est_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TOGGLE_BREAKDOWN_EN
    logic [ACC_W-1:0] acc_in;
    logic [ACC_W-1:0] acc_out;
    logic [ACC_W-1:0] acc_flag;
    logic [ACC_W-1:0] in_sum_c;
    logic [ACC_W-1:0] out_sum_c;
    logic [ACC_W-1:0] flag_sum_c;
    logic [T_W-1:0]   in_c;
    logic [T_W-1:0]   out_c;
    logic [T_W-1:0]   flag_c;

    always_comb begin
        in_c   = '0;
        out_c  = '0;
        flag_c = '0;
        if (primed) begin
            in_c   = T_W'(cnt_x) + T_W'(cnt_y);
            out_c  = T_W'(cnt_z);
            flag_c = T_W'(cnt_f);
        end
        in_sum_c   = ACC_W'(sat_add(acc_in, in_c));
        out_sum_c  = ACC_W'(sat_add(acc_out, out_c));
        flag_sum_c = ACC_W'(sat_add(acc_flag, flag_c));
    end

    // Unweighted per-class sums follow the same window/handshake as est_energy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_in       <= '0;
            acc_out      <= '0;
            acc_flag     <= '0;
            est_in_tog   <= '0;
            est_out_tog  <= '0;
            est_flag_tog <= '0;
        end else if (start) begin
            acc_in   <= '0;
            acc_out  <= '0;
            acc_flag <= '0;
        end else if (state == ACCUM && accept_c) begin
            acc_in   <= in_sum_c;
            acc_out  <= out_sum_c;
            acc_flag <= flag_sum_c;
            if (last_c) begin
                est_in_tog   <= in_sum_c;
                est_out_tog  <= out_sum_c;
                est_flag_tog <= flag_sum_c;
            end
        end else if (state == REPORT && est_ready) begin
            acc_in   <= '0;
            acc_out  <= '0;
            acc_flag <= '0;
        end
    end
`else
    // Per-class breakdown counters not built
`endif

endmodule

// File: tb/tb_alu_toggle_monitor.sv
// Self-checking bench: three monitor instances (window 16 / 4 / 8 with 6-bit acc) on one sample stream.
module tb_alu_toggle_monitor;

    localparam int WT_IN   = 1;
    localparam int WT_OUT  = 2;
    localparam int WT_FLAG = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        smp_valid = 1'b0;
    logic        est_ready = 1'b0;
    logic [15:0] smp_x = '0;
    logic [15:0] smp_y = '0;
    logic [15:0] smp_z = '0;
    logic [4:0]  smp_flags = '0;

    logic        a_ready, a_valid, a_busy, a_ovf;
    logic [23:0] a_energy;
    logic [4:0]  a_samples;
    logic        b_ready, b_valid, b_busy, b_ovf;
    logic [23:0] b_energy;
    logic [2:0]  b_samples;
    logic        c_ready, c_valid, c_busy, c_ovf;
    logic [5:0]  c_energy;
    logic [3:0]  c_samples;
`ifdef TOGGLE_BREAKDOWN_EN
    logic [23:0] a_in, a_out, a_flag, b_in, b_out, b_flag;
    logic [5:0]  c_in, c_out, c_flag;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_toggle_monitor u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_ready(a_ready),
        .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z), .smp_flags(smp_flags),
        .est_valid(a_valid), .est_ready(est_ready), .est_energy(a_energy),
        .est_samples(a_samples), .busy(a_busy), .overflow(a_ovf)
`ifdef TOGGLE_BREAKDOWN_EN
        , .est_in_tog(a_in), .est_out_tog(a_out), .est_flag_tog(a_flag)
`endif
    );

    alu_toggle_monitor #(.WIN_LOG2(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_ready(b_ready),
        .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z), .smp_flags(smp_flags),
        .est_valid(b_valid), .est_ready(est_ready), .est_energy(b_energy),
        .est_samples(b_samples), .busy(b_busy), .overflow(b_ovf)
`ifdef TOGGLE_BREAKDOWN_EN
        , .est_in_tog(b_in), .est_out_tog(b_out), .est_flag_tog(b_flag)
`endif
    );

    alu_toggle_monitor #(.WIN_LOG2(3), .ACC_W(6)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_ready(c_ready),
        .smp_x(smp_x), .smp_y(smp_y), .smp_z(smp_z), .smp_flags(smp_flags),
        .est_valid(c_valid), .est_ready(est_ready), .est_energy(c_energy),
        .est_samples(c_samples), .busy(c_busy), .overflow(c_ovf)
`ifdef TOGGLE_BREAKDOWN_EN
        , .est_in_tog(c_in), .est_out_tog(c_out), .est_flag_tog(c_flag)
`endif
    );

    function automatic logic get_ready(int s);
        return (s == 0) ? a_ready : (s == 1) ? b_ready : c_ready;
    endfunction
    function automatic logic get_valid(int s);
        return (s == 0) ? a_valid : (s == 1) ? b_valid : c_valid;
    endfunction
    function automatic logic get_ovf(int s);
        return (s == 0) ? a_ovf : (s == 1) ? b_ovf : c_ovf;
    endfunction
    function automatic logic [31:0] get_energy(int s);
        return (s == 0) ? 32'(a_energy) : (s == 1) ? 32'(b_energy) : 32'(c_energy);
    endfunction
    function automatic logic [31:0] get_samples(int s);
        return (s == 0) ? 32'(a_samples) : (s == 1) ? 32'(b_samples) : 32'(c_samples);
    endfunction

    // Reference: weighted Hamming distance between two samples
    function automatic int tog_energy(logic [15:0] x, logic [15:0] px, logic [15:0] y,
                                      logic [15:0] py, logic [15:0] z, logic [15:0] pz,
                                      logic [4:0] f, logic [4:0] pf);
        return WT_IN * ($countones(x ^ px) + $countones(y ^ py))
             + WT_OUT * $countones(z ^ pz) + WT_FLAG * $countones(f ^ pf);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(int sel, logic [15:0] x, logic [15:0] y, logic [15:0] z, logic [4:0] f);
        smp_x = x; smp_y = y; smp_z = z; smp_flags = f;
        smp_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (get_ready(sel)) begin
                @(negedge clk);
                smp_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        smp_valid = 1'b0;
        timeout_fail("send");
    endtask

    task automatic wait_est(int sel);
        for (int i = 0; i < 50; i++) begin
            if (get_valid(sel)) return;
            @(negedge clk);
        end
        timeout_fail("wait_est");
    endtask

    task automatic handshake();
        est_ready = 1'b1;
        @(negedge clk);
        est_ready = 1'b0;
    endtask

    typedef struct {
        int          sel;
        int          n;
        logic [15:0] x0, x1, y0, y1, z0, z1;
        logic [4:0]  f0, f1;
        logic [31:0] exp_e;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] px, py, pz, x, y, z;
        logic [4:0]  pf, f;
        logic        primed;
        int          exp_e;
`ifdef TOGGLE_BREAKDOWN_EN
        int          exp_in, exp_out, exp_flag;
`endif

        vecs[0] = '{0, 16, 16'h4F80, 16'h4F80, 16'h1234, 16'h1234, 16'h6134, 16'h6134, 5'h00, 5'h00, 32'd0,    1'b0};
        vecs[1] = '{1, 4,  16'h0000, 16'hFFFF, 16'h1234, 16'h1234, 16'h6134, 16'h6134, 5'h00, 5'h00, 32'd48,   1'b0};
        vecs[2] = '{1, 4,  16'h4F80, 16'h4F80, 16'h1234, 16'h1234, 16'h0000, 16'hFFFF, 5'h00, 5'h00, 32'd96,   1'b0};
        vecs[3] = '{1, 4,  16'h4F80, 16'h4F80, 16'h1234, 16'h1234, 16'h0000, 16'hFFFF, 5'h00, 5'h1F, 32'd111,  1'b0};
        vecs[4] = '{2, 8,  16'hAAAA, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 5'h00, 5'h00, 32'd63,   1'b1};
        vecs[5] = '{0, 16, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 5'h00, 5'h1F, 32'd1035, 1'b0};
        vecs[6] = '{1, 4,  16'h0001, 16'h0003, 16'h8000, 16'h0000, 16'h00FF, 16'h0F0F, 5'h01, 5'h02, 32'd60,   1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",   32'(a_ready), 0);
        check("rst_busy",    32'(a_busy), 0);
        check("rst_valid",   32'(a_valid), 0);
        check("rst_energy",  get_energy(0), 0);
        check("rst_samples", get_samples(0), 0);
        check("rst_ovf",     32'(a_ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(a_ready), 0);

        // Async reset mid-window with u_b holding an estimate
        do_start();
        check("start_busy",  32'(a_busy), 1);
        check("start_ready", 32'(a_ready), 1);
        for (int k = 0; k < 4; k++) send(0, 16'(k * 7), 16'hFFFF, 16'(k), 5'(k));
        check("pre_rst_b_valid", 32'(b_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy",    32'(a_busy), 0);
        check("mid_rst_ready",   32'(a_ready), 0);
        check("mid_rst_b_valid", 32'(b_valid), 0);
        check("mid_rst_b_energy", get_energy(1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(a_ready), 0);

        // Table-driven windows with alternating patterns
        foreach (vecs[v]) begin
            do_start();
            for (int k = 0; k < vecs[v].n; k++) begin
                if (k % 2 == 0) send(vecs[v].sel, vecs[v].x0, vecs[v].y0, vecs[v].z0, vecs[v].f0);
                else            send(vecs[v].sel, vecs[v].x1, vecs[v].y1, vecs[v].z1, vecs[v].f1);
            end
            wait_est(vecs[v].sel);
            check($sformatf("vec%0d_energy", v),  get_energy(vecs[v].sel), vecs[v].exp_e);
            check($sformatf("vec%0d_samples", v), get_samples(vecs[v].sel), 32'(vecs[v].n));
            check($sformatf("vec%0d_ovf", v),     32'(get_ovf(vecs[v].sel)), 32'(vecs[v].exp_ovf));
            if (vecs[v].sel == 2) begin
                do_start();
                check("ovf_cleared_by_start", 32'(c_ovf), 0);
            end
            handshake();
        end

        // Randomized windows on u_a against the reference model, with backpressure
        do_start();
        primed = 1'b0;
        px = '0; py = '0; pz = '0; pf = '0;
        for (int w = 0; w < 3; w++) begin
            exp_e = 0;
`ifdef TOGGLE_BREAKDOWN_EN
            exp_in = 0; exp_out = 0; exp_flag = 0;
`endif
            for (int k = 0; k < 16; k++) begin
                x = 16'($urandom()); y = 16'($urandom());
                z = ($urandom_range(0, 3) == 0) ? pz : 16'($urandom());
                f = 5'($urandom());
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(0, x, y, z, f);
                if (primed) begin
                    exp_e += tog_energy(x, px, y, py, z, pz, f, pf);
`ifdef TOGGLE_BREAKDOWN_EN
                    exp_in   += $countones(x ^ px) + $countones(y ^ py);
                    exp_out  += $countones(z ^ pz);
                    exp_flag += $countones(f ^ pf);
`endif
                end
                primed = 1'b1;
                px = x; py = y; pz = z; pf = f;
            end
            wait_est(0);
            check($sformatf("rnd%0d_energy", w),  get_energy(0), 32'(exp_e));
            check($sformatf("rnd%0d_samples", w), get_samples(0), 16);
            check($sformatf("rnd%0d_ovf", w),     32'(a_ovf), 0);
`ifdef TOGGLE_BREAKDOWN_EN
            check($sformatf("rnd%0d_in", w),   32'(a_in), 32'(exp_in));
            check($sformatf("rnd%0d_out", w),  32'(a_out), 32'(exp_out));
            check($sformatf("rnd%0d_flag", w), 32'(a_flag), 32'(exp_flag));
`endif
            if (w == 0) begin
                // Hold est_ready low while a sample is offered
                smp_x = 16'($urandom()); smp_y = 16'($urandom());
                smp_valid = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check("bp_valid",  32'(a_valid), 1);
                    check("bp_energy", get_energy(0), 32'(exp_e));
                    check("bp_ready",  32'(a_ready), 0);
                end
                smp_valid = 1'b0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
            check($sformatf("rnd%0d_valid_drop", w), 32'(a_valid), 0);
        end

        // start while an estimate is pending discards it
        for (int k = 0; k < 16; k++) send(0, 16'($urandom()), 16'h0, 16'h0, 5'h0);
        wait_est(0);
        do_start();
        check("restart_valid", 32'(a_valid), 0);
        check("restart_ready", 32'(a_ready), 1);
        check("restart_busy",  32'(a_busy), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
